imem_fetch_ctrl: RTL and testbench

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

---
 rtl/imem_fetch_ctrl.sv | 114 +++++++++++
 tb/tb_imem_fetch_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: assembles 32-bit little-endian words from a
// byte-wide instruction memory, with freeze handshake, branch redirect and fault.
module imem_fetch_ctrl #(
  parameter int unsigned MEM_BYTES = 192,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [7:0]  mem_rdata,
  input  logic        inst_ready,
  output logic        inst_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        addr_fault,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {FETCH, HOLD, FAULT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] word_q, word_d;
  logic        addr_fault_q, addr_fault_d;
  logic [15:0] count_q, count_d;
  logic [31:0] next_pc;

  // 33-bit compare so a word straddling the 2^32 wrap counts as out of range.
  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} + 33'd3) < 33'(MEM_BYTES);
  endfunction

  assign next_pc = fetch_pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fetch_pc_d   = fetch_pc_q;
    word_d       = word_q;
    addr_fault_d = addr_fault_q;
    count_d      = count_q;

    unique case (state_q)
      FETCH: begin
        word_d[{cnt_q, 3'b000} +: 8] = mem_rdata;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = HOLD;
      end
      HOLD: begin
        if (inst_ready) begin
          count_d    = count_q + 16'd1;
          fetch_pc_d = next_pc;
          cnt_d      = 2'd0;
          if (in_range(next_pc)) begin
            state_d = FETCH;
          end else begin
            state_d      = FAULT;
            addr_fault_d = 1'b1;
          end
        end
      end
      FAULT: ;
      default: state_d = FAULT;
    endcase

    // Redirect overrides both byte capture and word acceptance.
    if (branch_taken) begin
      word_d     = word_q;
      count_d    = count_q;
      fetch_pc_d = branch_addr;
      cnt_d      = 2'd0;
      if (branch_addr[1:0] == 2'b00 && in_range(branch_addr)) begin
        state_d      = FETCH;
        addr_fault_d = 1'b0;
      end else begin
        state_d      = FAULT;
        addr_fault_d = 1'b1;
      end
    end
  end

  // NOTE: the byte-lane word is reset too, because instruction must read 0
  // after reset rather than leftover bytes from an abandoned fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      cnt_q        <= 2'd0;
      fetch_pc_q   <= RESET_PC;
      word_q       <= 32'h0;
      addr_fault_q <= 1'b0;
      count_q      <= 16'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fetch_pc_q   <= fetch_pc_d;
      word_q       <= word_d;
      addr_fault_q <= addr_fault_d;
      count_q      <= count_d;
    end
  end

  assign mem_rd_en   = !rst && (state_q == FETCH);
  assign mem_addr    = rst ? RESET_PC : (fetch_pc_q + {30'd0, cnt_q});
  assign inst_valid  = (state_q == HOLD);
  assign instruction = word_q;
  assign pc          = fetch_pc_q;
  assign addr_fault  = addr_fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed self-checking bench for imem_fetch_ctrl with a 192-byte memory model.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_rdata;
  logic        inst_ready;
  logic        inst_valid;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        addr_fault;
  logic [15:0] fetch_count;

  logic [7:0] mem [0:191];
  int total = 0;
  int bad = 0;
  logic bad_read = 1'b0;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(.MEM_BYTES(192), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .inst_ready(inst_ready), .inst_valid(inst_valid),
    .instruction(instruction), .pc(pc), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .addr_fault(addr_fault), .fetch_count(fetch_count)
  );

  assign mem_rdata = (mem_addr < 32'd192) ? mem[mem_addr[7:0]] : 8'hEE;

  always @(posedge clk)
    if (mem_rd_en && mem_addr >= 32'd192) bad_read = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_instr"}, instruction, 32'h0);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_fault"}, 32'(addr_fault), 32'd0);
    check({tag, "_count"}, 32'(fetch_count), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 192; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h22; mem[3] = 8'h00;

    rst = 1'b1; inst_ready = 1'b1; branch_taken = 1'b0; branch_addr = 32'h0;
    step(2);
    check_reset_vals("rst");
    check("rst_rden", 32'(mem_rd_en), 32'd0);
    check("rst_addr", mem_addr, 32'h0);

    // First word from address 0: four byte reads, valid on the fifth cycle.
    rst = 1'b0; #1;
    check("c1_addr", mem_addr, 32'h0);
    check("c1_rden", 32'(mem_rd_en), 32'd1);
    step(); check("c2_addr", mem_addr, 32'h1);
    step(); check("c3_addr", mem_addr, 32'h2);
    step(); check("c4_addr", mem_addr, 32'h3);
    step();
    check("w0_valid", 32'(inst_valid), 32'd1);
    check("w0_instr", instruction, 32'h00220000);
    check("w0_pc", pc, 32'h0);
    check("w0_rden", 32'(mem_rd_en), 32'd0);

    // Freeze for ten cycles.
    inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("frz_valid", 32'(inst_valid), 32'd1);
      check("frz_instr", instruction, 32'h00220000);
      check("frz_rden", 32'(mem_rd_en), 32'd0);
    end
    inst_ready = 1'b1;
    step();
    check("acc0_count", 32'(fetch_count), 32'd1);
    check("acc0_valid", 32'(inst_valid), 32'd0);
    check("acc0_addr", mem_addr, 32'h4);

    step(4);
    check("w4_valid", 32'(inst_valid), 32'd1);
    check("w4_instr", instruction, 32'h342D261F);
    check("w4_pc", pc, 32'h4);

    // Branch while the word at 0x8 is at byte 2.
    step(); check("w8_count", 32'(fetch_count), 32'd2);
    step(2); check("w8_cnt2_addr", mem_addr, 32'hA);
    branch_taken = 1'b1; branch_addr = 32'h10;
    step(); branch_taken = 1'b0;
    check("br10_addr", mem_addr, 32'h10);
    check("br10_valid", 32'(inst_valid), 32'd0);
    check("br10_count", 32'(fetch_count), 32'd2);
    step(4);
    check("w10_valid", 32'(inst_valid), 32'd1);
    check("w10_pc", pc, 32'h10);
    check("w10_instr", instruction, 32'h88817A73);

    // Misaligned branch coinciding with an accept: branch wins, no count.
    branch_taken = 1'b1; branch_addr = 32'h12;
    step(); branch_taken = 1'b0;
    check("mis_fault", 32'(addr_fault), 32'd1);
    check("mis_rden", 32'(mem_rd_en), 32'd0);
    check("mis_valid", 32'(inst_valid), 32'd0);
    check("mis_count", 32'(fetch_count), 32'd2);
    step(2);
    check("mis_sticky", 32'(addr_fault), 32'd1);
    check("mis_rden2", 32'(mem_rd_en), 32'd0);

    // Recover with a valid branch.
    branch_taken = 1'b1; branch_addr = 32'h4;
    step(); branch_taken = 1'b0;
    check("rec_fault", 32'(addr_fault), 32'd0);
    check("rec_addr", mem_addr, 32'h4);
    check("rec_rden", 32'(mem_rd_en), 32'd1);
    step(4);
    check("rec_valid", 32'(inst_valid), 32'd1);
    check("rec_instr", instruction, 32'h342D261F);
    check("rec_pc", pc, 32'h4);

    // Run off the end of memory.
    branch_taken = 1'b1; branch_addr = 32'hB8;
    step(); branch_taken = 1'b0;
    check("b8_count", 32'(fetch_count), 32'd2);
    check("b8_addr", mem_addr, 32'hB8);
    step(4);
    check("wb8_instr", instruction, 32'h2019120B);
    check("wb8_pc", pc, 32'hB8);
    step(); check("bc_count", 32'(fetch_count), 32'd3);
    step(4);
    check("wbc_valid", 32'(inst_valid), 32'd1);
    check("wbc_instr", instruction, 32'h3C352E27);
    check("wbc_pc", pc, 32'hBC);
    step();
    check("end_count", 32'(fetch_count), 32'd4);
    check("end_fault", 32'(addr_fault), 32'd1);
    check("end_rden", 32'(mem_rd_en), 32'd0);
    check("end_valid", 32'(inst_valid), 32'd0);
    check("end_pc", pc, 32'hC0);

    // Aligned target whose word wraps past 2^32.
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
    step(); branch_taken = 1'b0;
    check("wrap_fault", 32'(addr_fault), 32'd1);
    check("wrap_rden", 32'(mem_rd_en), 32'd0);

    // Reset in the middle of a fetch (cnt=1).
    branch_taken = 1'b1; branch_addr = 32'h20;
    step(); branch_taken = 1'b0;
    check("b20_fault", 32'(addr_fault), 32'd0);
    step(); check("b20_cnt1", mem_addr, 32'h21);
    rst = 1'b1;
    step();
    check_reset_vals("rstf");
    check("rstf_rden", 32'(mem_rd_en), 32'd0);
    check("rstf_addr", mem_addr, 32'h0);
    rst = 1'b0; #1;
    check("rstf_restart", mem_addr, 32'h0);
    check("rstf_rden1", 32'(mem_rd_en), 32'd1);
    step(4);
    check("rw0_instr", instruction, 32'h00220000);

    // Reset during HOLD with a simultaneous branch: reset wins.
    inst_ready = 1'b0; rst = 1'b1; branch_taken = 1'b1; branch_addr = 32'h40;
    step();
    rst = 1'b0; branch_taken = 1'b0; #1;
    check_reset_vals("rsth");
    check("rsth_addr", mem_addr, 32'h0);
    check("rsth_rden", 32'(mem_rd_en), 32'd1);
    inst_ready = 1'b1;
    step(2);

    check("no_oob_read", 32'(bad_read), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
